mod_exp_core: RTL and testbench
===============================

MOD_EXP_CORE -- requirements
Module: mod_exp_core

Interface
REQ-001 The module SHALL have parameter WORD_WIDTH, default 32, giving the operand and result width W (W >= 4).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin an operation, sampled only in IDLE.
REQ-005 The module SHALL have ports base_i, exp_i and mod_i, each input, W bits: message/base, exponent (e or d) and modulus N, captured when start is accepted.
REQ-006 The module SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-007 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-008 The module SHALL have port result_o, output, W bits: base_i^exp_i mod mod_i.
REQ-009 The module SHALL have port error_o, output, 1 bit: the last accepted request had mod_i < 2.

Function
REQ-010 The module SHALL implement FSM states IDLE, RED, SQR, MUL and FIN.
REQ-011 In IDLE, start=1 with mod_i >= 2 SHALL capture base_i, exp_i and mod_i, clear error_o, set busy, and go to RED.
REQ-012 In IDLE, start=1 with mod_i < 2 SHALL set result_o=0 and error_o=1, pulse done on the next cycle, keep busy low, and stay in IDLE.
REQ-013 All modular products SHALL use one bit-serial interleaved multiplier mm(A,B), where A < N, taking exactly W cycles.
- Scan B from MSB to LSB.
- Each step: R' = 2R + b_i*A.
- Then subtract 2N if R' >= 2N, else subtract N if R' >= N.
- Internal R width is W+2 bits; the result is always < N.
REQ-014 RED (W cycles) SHALL compute base_r = mm(1, base), so base_i >= N is reduced correctly; acc SHALL be initialised to 1.
REQ-015 The module SHALL process the exponent MSB to LSB over all W bits, regardless of leading zeros, for constant timing. For each bit:
- SQR (W cycles): acc = mm(acc, acc).
- MUL (W cycles): t = mm(acc, base_r); acc = t if the exponent bit is 1, else acc unchanged.
REQ-016 After the MUL of bit 0, the FSM SHALL enter FIN.
- FIN loads result_o = acc, pulses done for one cycle, drops busy, and returns to IDLE.
- done SHALL occur exactly W + 2W^2 + 1 rising edges after the edge that accepted start (W=8: 137; W=16: 529; W=32: 2081).
REQ-017 start while busy SHALL be ignored, and input changes during busy SHALL have no effect.
REQ-018 result_o and error_o SHALL hold their values until the next accepted start.
REQ-019 exp_i=0 SHALL yield result_o=1 (including base_i=0), and base_i a multiple of N with exp_i > 0 SHALL yield 0.
REQ-020 start may be reasserted in the cycle after done, and a new operation SHALL begin with no idle gap required.

Reset
REQ-021 rst=0 SHALL immediately, without waiting for a clock edge, force:
- state IDLE;
- busy=0, done=0, error_o=0;
- result_o=0;
- all internal registers = 0.
REQ-022 Reset asserted mid-operation SHALL abort the operation with no done pulse; after rst is released the module SHALL accept start on the first rising edge.

Verification
REQ-023 W=8, base=4, exp=13, N=97 -> done after 137 edges, result_o=93, error_o=0, busy high for exactly the preceding cycles.
REQ-024 W=16, base=65, exp=17, N=3233 -> result_o=2790; then base=2790, exp=2753, N=3233 started the cycle after done -> result_o=65, each operation taking 529 edges.
REQ-025 W=8 corner cases:
- base=200, exp=1, N=97 -> 6.
- base=0, exp=0, N=97 -> 1.
- base=5, exp=255, N=255 -> result equal to a software model.
- A randomized sweep against the software model with N >= 2 -> all results match.
REQ-026 W=8, N=1 or N=0 with start -> done one cycle later, result_o=0, error_o=1, busy never high; a following valid request clears error_o.
REQ-027 W=8, start pulsed again at cycle 50 of an operation with different inputs -> ignored, and the original result is delivered on time.
REQ-028 W=8, rst driven low at cycle 70, between clock edges -> busy drops immediately, no done pulse; a new request after release completes correctly in 137 edges.

Source files
------------

// File: rtl/mod_exp_core.sv
// mod_exp_core: constant-time modular exponentiation (base^exp mod N),
// left-to-right square-and-multiply built on one bit-serial interleaved
// modular multiplier that takes exactly W cycles per product.
module mod_exp_core #(
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] base_i,
    input  logic [WORD_WIDTH-1:0] exp_i,
    input  logic [WORD_WIDTH-1:0] mod_i,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] result_o,
    output logic                  error_o
);

    localparam int unsigned W  = WORD_WIDTH;
    localparam int unsigned CW = $clog2(WORD_WIDTH);
    localparam int unsigned RW = WORD_WIDTH + 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RED  = 3'd1,
        SQR  = 3'd2,
        MUL  = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic [W-1:0]   base_q;
    logic [W-1:0]   exp_q;
    logic [W-1:0]   mod_q;
    logic [W-1:0]   base_r;
    logic [W-1:0]   acc;
    logic [W-1:0]   r;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  bit_idx;

    logic [W-1:0]   a_op;
    logic [W-1:0]   b_op;
    logic           b_bit;
    logic [RW-1:0]  r2;
    logic [RW-1:0]  n1;
    logic [RW-1:0]  n2;
    logic [W-1:0]   r_next;
    logic           mm_last;
    logic           mod_ok;

    // Multiplier operand routing: RED reduces base via mm(1, base), SQR uses acc*acc, MUL uses acc*base_r
    always_comb begin
        a_op = acc;
        b_op = acc;
        case (state_q)
            RED:     begin a_op = W'(1); b_op = base_q; end
            MUL:     b_op = base_r;
            default: ;
        endcase
    end

    // One interleaved step: R' = 2R + b*A, then fold back below N by subtracting 2N or N
    always_comb begin
        b_bit = b_op[CW'(W - 1) - cnt];
        n1    = {2'b00, mod_q};
        n2    = {1'b0, mod_q, 1'b0};
        r2    = {1'b0, r, 1'b0} + (b_bit ? {2'b00, a_op} : '0);
        if (r2 >= n2) begin
            r_next = W'(r2 - n2);
        end else if (r2 >= n1) begin
            r_next = W'(r2 - n1);
        end else begin
            r_next = W'(r2);
        end
        mm_last = (cnt == CW'(W - 1));
        mod_ok  = (mod_i >= W'(2));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every exponent bit costs one square and one (possibly discarded) multiply
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && mod_ok) state_d = RED;
            RED:  if (mm_last) state_d = SQR;
            SQR:  if (mm_last) state_d = MUL;
            MUL:  if (mm_last) state_d = (bit_idx == '0) ? FIN : SQR;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q   <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            base_r   <= '0;
            acc      <= '0;
            r        <= '0;
            cnt      <= '0;
            bit_idx  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result_o <= '0;
            error_o  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (mod_ok) begin
                            base_q  <= base_i;
                            exp_q   <= exp_i;
                            mod_q   <= mod_i;
                            error_o <= 1'b0;
                            busy    <= 1'b1;
                            acc     <= W'(1);
                            r       <= '0;
                            cnt     <= '0;
                            bit_idx <= CW'(W - 1);
                        end else begin
                            result_o <= '0;
                            error_o  <= 1'b1;
                            done     <= 1'b1;
                        end
                    end
                end
                RED, SQR, MUL: begin
                    if (mm_last) begin
                        r   <= '0;
                        cnt <= '0;
                        if (state_q == RED) begin
                            base_r <= r_next;
                        end else if (state_q == SQR) begin
                            acc <= r_next;
                        end else begin
                            if (exp_q[bit_idx]) acc <= r_next;
                            if (bit_idx != '0) bit_idx <= bit_idx - CW'(1);
                        end
                    end else begin
                        r   <= r_next;
                        cnt <= cnt + CW'(1);
                    end
                end
                FIN: begin
                    result_o <= acc;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_core.sv
// Scoreboard bench for mod_exp_core: W=8 and W=16 instances, expected
// results from a plain repeated-multiplication model.
module tb_mod_exp_core;

    localparam int LAT8  = 8 + 2 * 8 * 8 + 1;
    localparam int LAT16 = 16 + 2 * 16 * 16 + 1;

    typedef struct {
        logic [15:0] res;
        logic        err;
        int          due;
        int          bcy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start8 = 1'b0;
    logic [7:0]  base8 = '0, exp8 = '0, mod8 = '0;
    logic        busy8, done8, err8;
    logic [7:0]  result8;
    logic        start16 = 1'b0;
    logic [15:0] base16 = '0, exp16 = '0, mod16 = '0;
    logic        busy16, done16, err16;
    logic [15:0] result16;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   bcnt8 = 0;
    int   bcnt16 = 0;
    exp_t q8[$];
    exp_t q16[$];
    exp_t e8, e16;

    mod_exp_core #(.WORD_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .base_i(base8), .exp_i(exp8),
        .mod_i(mod8), .busy(busy8), .done(done8), .result_o(result8), .error_o(err8)
    );

    mod_exp_core #(.WORD_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .base_i(base16), .exp_i(exp16),
        .mod_i(mod16), .busy(busy16), .done(done16), .result_o(result16), .error_o(err16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] ref_modexp(input int unsigned b, input int unsigned e,
                                               input int unsigned n);
        longint unsigned acc;
        if (n < 2) return 16'd0;
        acc = 64'd1 % 64'(n);
        for (int unsigned i = 0; i < e; i++) acc = (acc * (64'(b) % 64'(n))) % 64'(n);
        return 16'(acc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // W=8 monitor: pop and compare on each done, flag overdue or spurious completions
    always @(negedge clk) begin
        if (!rst) begin
            bcnt8 = 0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                chk("spurious_done8", 32'(done8), 32'd0);
            end else begin
                e8 = q8.pop_front();
                chk("result8", 32'(result8), 32'(e8.res));
                chk("error8", 32'(err8), 32'(e8.err));
                chk("latency8", 32'(cyc), 32'(e8.due));
                chk("busy_cycles8", 32'(bcnt8), 32'(e8.bcy));
                chk("busy_at_done8", 32'(busy8), 32'd0);
            end
            bcnt8 = 0;
        end else begin
            if (busy8) bcnt8++;
            if (q8.size() > 0 && cyc > q8[0].due) begin
                e8 = q8.pop_front();
                chk("done8_overdue", 32'(done8), 32'd1);
            end
        end
    end

    // W=16 monitor
    always @(negedge clk) begin
        if (!rst) begin
            bcnt16 = 0;
        end else if (done16) begin
            if (q16.size() == 0) begin
                chk("spurious_done16", 32'(done16), 32'd0);
            end else begin
                e16 = q16.pop_front();
                chk("result16", 32'(result16), 32'(e16.res));
                chk("error16", 32'(err16), 32'(e16.err));
                chk("latency16", 32'(cyc), 32'(e16.due));
                chk("busy_cycles16", 32'(bcnt16), 32'(e16.bcy));
            end
            bcnt16 = 0;
        end else begin
            if (busy16) bcnt16++;
            if (q16.size() > 0 && cyc > q16[0].due) begin
                e16 = q16.pop_front();
                chk("done16_overdue", 32'(done16), 32'd1);
            end
        end
    end

    // Issue one W=8 request at a falling edge; inputs are scrambled while busy
    task automatic issue8(input logic [7:0] b, input logic [7:0] e, input logic [7:0] n);
        exp_t x;
        base8  = b;
        exp8   = e;
        mod8   = n;
        start8 = 1'b1;
        x.res  = ref_modexp(32'(b), 32'(e), 32'(n));
        x.err  = (n < 8'd2);
        x.due  = cyc + 1 + ((n < 8'd2) ? 0 : LAT8);
        x.bcy  = (n < 8'd2) ? 0 : LAT8;
        q8.push_back(x);
        @(negedge clk);
        start8 = 1'b0;
        base8  = 8'($urandom);
        exp8   = 8'($urandom);
        mod8   = 8'($urandom);
    endtask

    task automatic issue16(input logic [15:0] b, input logic [15:0] e, input logic [15:0] n);
        exp_t x;
        base16  = b;
        exp16   = e;
        mod16   = n;
        start16 = 1'b1;
        x.res   = ref_modexp(32'(b), 32'(e), 32'(n));
        x.err   = (n < 16'd2);
        x.due   = cyc + 1 + ((n < 16'd2) ? 0 : LAT16);
        x.bcy   = (n < 16'd2) ? 0 : LAT16;
        q16.push_back(x);
        @(negedge clk);
        start16 = 1'b0;
        base16  = 16'($urandom);
        exp16   = 16'($urandom);
        mod16   = 16'($urandom);
    endtask

    task automatic wait_done8();
        for (int i = 0; i < LAT8 + 20; i++) begin
            if (done8) return;
            @(negedge clk);
        end
        chk("wait_done8_timeout", 32'(done8), 32'd1);
    endtask

    task automatic wait_done16();
        for (int i = 0; i < LAT16 + 20; i++) begin
            if (done16) return;
            @(negedge clk);
        end
        chk("wait_done16_timeout", 32'(done16), 32'd1);
    endtask

    initial begin
        #1;
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_result8", 32'(result8), 32'd0);
        chk("rst_error8", 32'(err8), 32'd0);
        chk("rst_busy16", 32'(busy16), 32'd0);
        chk("rst_result16", 32'(result16), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // RSA round trip at W=16, second request issued while done is high
        issue16(16'd65, 16'd17, 16'd3233);
        wait_done16();
        chk("rsa_encrypt16", 32'(result16), 32'd2790);
        issue16(16'd2790, 16'd2753, 16'd3233);
        wait_done16();
        chk("rsa_decrypt16", 32'(result16), 32'd65);

        // W=8 directed corners
        issue8(8'd4, 8'd13, 8'd97);
        wait_done8();
        chk("known_4_13_97", 32'(result8), 32'd93);
        issue8(8'd200, 8'd1, 8'd97);
        wait_done8();
        chk("base_ge_mod", 32'(result8), 32'd6);
        issue8(8'd0, 8'd0, 8'd97);
        wait_done8();
        chk("zero_pow_zero", 32'(result8), 32'd1);
        issue8(8'd194, 8'd5, 8'd97);
        wait_done8();
        chk("base_multiple_of_n", 32'(result8), 32'd0);
        issue8(8'd5, 8'd255, 8'd255);
        wait_done8();

        // Invalid moduli, then a valid request clears the error
        issue8(8'd9, 8'd7, 8'd1);
        wait_done8();
        chk("err_mod1", 32'(err8), 32'd1);
        issue8(8'd9, 8'd7, 8'd0);
        wait_done8();
        chk("err_mod0_busy", 32'(busy8), 32'd0);
        issue8(8'd3, 8'd5, 8'd7);
        wait_done8();
        chk("error_cleared", 32'(err8), 32'd0);

        // Start pulsed mid-operation with different inputs must be ignored
        issue8(8'd10, 8'd20, 8'd101);
        repeat (49) @(negedge clk);
        start8 = 1'b1;
        base8  = 8'd77;
        exp8   = 8'd3;
        mod8   = 8'd11;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8();

        // Randomized sweep
        for (int k = 0; k < 20; k++) begin
            issue8(8'($urandom), 8'($urandom), 8'($urandom_range(2, 255)));
            wait_done8();
        end

        // Asynchronous reset mid-operation, then an immediate new request
        issue8(8'd123, 8'd45, 8'd211);
        repeat (68) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy8), 32'd0);
        chk("async_rst_done", 32'(done8), 32'd0);
        q8.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        issue8(8'd4, 8'd13, 8'd97);
        wait_done8();
        chk("after_reset", 32'(result8), 32'd93);

        repeat (5) @(negedge clk);
        chk("queue8_drained", 32'(q8.size()), 32'd0);
        chk("queue16_drained", 32'(q16.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
